// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Host-side writer for the sequencer instruction RAM. A framed byte stream from
// the host link FIFO is parsed, 120-bit instruction words are assembled (MSB
// byte first) and written at consecutive RAM addresses.
//
// Frame: 0xA5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT*15 payload bytes, CHK
//   CHK is the 8-bit modular sum of every byte after 0xA5 up to the last
//   payload byte.
//
// Word layout: {flg[63:0], op_code[3:0], data[19:0], time_arg[31:0]}
//
// Parameters
//   ADDR_SIZE       RAM address width (address wraps modulo 2^ADDR_SIZE)
//   TIMEOUT_CYCLES  idle cycles allowed between bytes inside a frame
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   in_data      byte from host FIFO
//   in_valid     in_data valid
//   in_ready     byte accepted when in_valid && in_ready (low only in reset)
//   seq_idle     decoder stopped; frames are accepted only while high
//   mem_we       RAM write strobe, one cycle per word
//   mem_waddr    RAM write address
//   mem_wdata    RAM write data
//   busy         frame in progress
//   done         one-cycle pulse after the checksum byte is accepted
//   crc_err      checksum mismatch on the last frame; cleared by next LOAD
//   reject_err   one-cycle pulse: LOAD refused or aborted because seq_idle low
//   timeout_err  one-cycle pulse: frame aborted on inter-byte timeout
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 seq_idle,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_waddr,
  output logic [119:0]         mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_err,
  output logic                 reject_err,
  output logic                 timeout_err
);

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         WORD_BYTES = 15;
  localparam int         TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    PAYLOAD,
    CHECK
  } state_t;

  state_t               state;
  logic [7:0]           addr_hi;     // held until ADDR_LO completes the address
  logic [7:0]           cnt_hi;      // held until CNT_LO completes the count
  logic [7:0]           checksum;
  logic [ADDR_SIZE-1:0] addr;        // address of the word being assembled
  logic [15:0]          words_left;
  logic [3:0]           byte_cnt;    // payload bytes already in shift_reg
  logic [111:0]         shift_reg;   // first 14 bytes; the 15th joins at write time
  logic [TIMER_W-1:0]   timer;
  logic                 mem_we_q;
  logic                 done_q;
  logic                 accept;

  assign in_ready = !reset;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // The strobes are masked by reset so that a strobe registered just before
  // reset rises can never reach the RAM during the reset cycle itself.
  assign mem_we = mem_we_q && !reset;
  assign done   = done_q && !reset;

  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see the same pre-edge values; a blocking update would let later
  // statements in this block observe half-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers (shift_reg, mem_wdata) are reset too so
      // that every output reads 0 after reset, not just the control flags.
      state       <= IDLE;
      addr_hi     <= '0;
      cnt_hi      <= '0;
      checksum    <= '0;
      addr        <= '0;
      words_left  <= '0;
      byte_cnt    <= '0;
      shift_reg   <= '0;
      timer       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      done_q      <= 1'b0;
      crc_err     <= 1'b0;
      reject_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Pulse outputs default low; they are raised for exactly one cycle below.
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      reject_err  <= 1'b0;
      timeout_err <= 1'b0;

      if (state == IDLE) begin
        timer <= '0;
        // Anything other than the sync byte is dropped without comment.
        if (accept && in_data == SYNC_BYTE) begin
          if (seq_idle) begin
            crc_err  <= 1'b0;
            checksum <= '0;
            byte_cnt <= '0;
            state    <= ADDR_HI;
          end else begin
            reject_err <= 1'b1;
          end
        end
      end else if (!seq_idle) begin
        // Decoder left STOP mid-frame: abandon the frame and any partial word.
        // A strobe registered on the previous edge is already on the outputs
        // and still completes.
        reject_err <= 1'b1;
        state      <= IDLE;
        timer      <= '0;
        byte_cnt   <= '0;
      end else if (accept) begin
        timer <= '0;
        if (state != CHECK) begin
          checksum <= checksum + in_data;
        end

        case (state)
          ADDR_HI: begin
            addr_hi <= in_data;
            state   <= ADDR_LO;
          end
          ADDR_LO: begin
            // Bits above ADDR_SIZE-1 are dropped by the width cast.
            addr  <= ADDR_SIZE'({addr_hi, in_data});
            state <= CNT_HI;
          end
          CNT_HI: begin
            cnt_hi <= in_data;
            state  <= CNT_LO;
          end
          CNT_LO: begin
            words_left <= {cnt_hi, in_data};
            state      <= ({cnt_hi, in_data} == 16'd0) ? CHECK : PAYLOAD;
          end
          PAYLOAD: begin
            if (byte_cnt == 4'(WORD_BYTES - 1)) begin
              mem_we_q   <= 1'b1;
              mem_waddr  <= addr;
              mem_wdata  <= {shift_reg, in_data};
              addr       <= addr + ADDR_SIZE'(1);
              byte_cnt   <= '0;
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) begin
                state <= CHECK;
              end
            end else begin
              shift_reg <= {shift_reg[103:0], in_data};
              byte_cnt  <= byte_cnt + 4'd1;
            end
          end
          CHECK: begin
            // Words already written stay written; only the flag reports it.
            done_q  <= 1'b1;
            crc_err <= (in_data != checksum);
            state   <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
        // This cycle is the TIMEOUT_CYCLES-th consecutive one without a byte.
        timeout_err <= 1'b1;
        state       <= IDLE;
        timer       <= '0;
        byte_cnt    <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//
// Self-checking bench for instr_loader. Frames are built from whole 120-bit
// words by a reference model that derives the byte stream, the checksum, the
// expected write list (base address + index, wrapping at 2^16) and the
// expected crc_err. A negedge monitor records every write strobe and pulse.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam int ADDR_SIZE = 16;
  localparam int TO_CYCLES = 16;

  logic                 clk;
  logic                 reset;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 seq_idle;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [119:0]         mem_wdata;
  logic                 busy;
  logic                 done;
  logic                 crc_err;
  logic                 reject_err;
  logic                 timeout_err;

  instr_loader #(
    .ADDR_SIZE     (ADDR_SIZE),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .seq_idle   (seq_idle),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .crc_err    (crc_err),
    .reject_err (reject_err),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  a;
    logic [119:0] d;
  } wr_t;

  // Monitor state
  wr_t  got_q[$];
  int   done_cnt = 0;
  int   rej_cnt  = 0;
  int   to_cnt   = 0;
  logic last_crc = 1'b0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) got_q.push_back('{mem_waddr, mem_wdata});
    if (done === 1'b1) begin
      done_cnt++;
      last_crc = crc_err;
    end
    if (reject_err === 1'b1) rej_cnt++;
    if (timeout_err === 1'b1) to_cnt++;
  end

  // Reference model state
  logic [119:0] words[$];
  logic [7:0]   tx_q[$];
  wr_t          exp_q[$];
  logic         exp_crc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Builds the byte stream for a frame carrying 'words' at base 'addr'.
  // chk_delta != 0 corrupts the checksum byte by that amount.
  task automatic make_frame(input int addr, input int chk_delta);
    int sum;
    int n;
    n = words.size();
    tx_q  = {};
    exp_q = {};
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'((addr >> 8) & 255));
    tx_q.push_back(8'(addr & 255));
    tx_q.push_back(8'((n >> 8) & 255));
    tx_q.push_back(8'(n & 255));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 15; k++) tx_q.push_back(words[i][8*(14-k) +: 8]);
      exp_q.push_back('{16'((addr + i) % 65536), words[i]});
    end
    sum = 0;
    for (int i = 1; i < tx_q.size(); i++) sum = (sum + int'(tx_q[i])) % 256;
    tx_q.push_back(8'((sum + chk_delta) % 256));
    exp_crc = ((chk_delta % 256) != 0);
  endtask

  // Sends the current frame with random idle gaps (well below the timeout)
  // and random junk in front of it, then checks writes, done and crc_err.
  task automatic run_frame(input string tag);
    int   d0;
    logic [7:0] junk;
    got_q = {};
    d0 = done_cnt;
    repeat ($urandom_range(0, 3)) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h5A;
      tick(1'b1, junk);
    end
    foreach (tx_q[i]) begin
      repeat ($urandom_range(0, 3)) tick(1'b0, 8'h00);
      tick(1'b1, tx_q[i]);
    end
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    check({tag, " write count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s wr%0d addr", tag, i), 128'(got_q[i].a), 128'(exp_q[i].a));
      check($sformatf("%s wr%0d data", tag, i), 128'(got_q[i].d), 128'(exp_q[i].d));
    end
    check({tag, " done pulses"}, 128'(done_cnt - d0), 128'(1));
    check({tag, " crc_err"}, 128'(last_crc), 128'(exp_crc));
    check({tag, " busy after"}, 128'(busy), 128'(0));
  endtask

  function automatic logic [119:0] rand_word();
    logic [119:0] w;
    for (int i = 0; i < 4; i++) w[32*i +: 32] = 32'($urandom);
    return w;
  endfunction

  int r0;
  int t0;

  initial begin
    reset    = 1'b1;
    seq_idle = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    check("in_ready during reset", 128'(in_ready), 128'(0));
    reset = 1'b0;
    tick(1'b0, 8'h00);
    check("reset in_ready", 128'(in_ready), 128'(1));
    check("reset outputs", 128'({mem_we, busy, done, crc_err, reject_err, timeout_err}), 128'(0));
    check("reset waddr/wdata", 128'({mem_waddr, mem_wdata} != 0), 128'(0));

    // 1: directed single word at 0x0005
    words = {120'h0102030405060708090A0B0C0D0E0F};
    make_frame(5, 0);
    run_frame("t1");

    // 2: address wrap 0xFFFF -> 0x0000
    words = {rand_word(), rand_word()};
    make_frame(16'hFFFF, 0);
    run_frame("t2");

    // 3: bad checksum, word still written, crc_err held until next LOAD
    words = {120'h0102030405060708090A0B0C0D0E0F};
    make_frame(5, 1);
    run_frame("t3");
    repeat (5) tick(1'b0, 8'h00);
    check("t3 crc_err holds", 128'(crc_err), 128'(1));
    tick(1'b1, 8'hA5);
    check("t3 crc_err cleared by LOAD", 128'(crc_err), 128'(0));
    check("t3 busy after LOAD", 128'(busy), 128'(1));
    r0 = rej_cnt;
    seq_idle = 1'b0;
    tick(1'b0, 8'h00);
    check("t3 abort reject_err", 128'(reject_err), 128'(1));
    check("t3 abort busy", 128'(busy), 128'(0));
    seq_idle = 1'b1;
    tick(1'b0, 8'h00);
    check("t3 reject pulse count", 128'(rej_cnt - r0), 128'(1));

    // 4: LOAD refused while the sequencer runs (directed frame has no 0xA5 inside)
    words = {120'h0102030405060708090A0B0C0D0E0F};
    make_frame(5, 0);
    got_q = {};
    r0 = rej_cnt;
    t0 = done_cnt;
    seq_idle = 1'b0;
    foreach (tx_q[i]) tick(1'b1, tx_q[i]);
    tick(1'b0, 8'h00);
    check("t4 reject pulses", 128'(rej_cnt - r0), 128'(1));
    check("t4 no writes", 128'(got_q.size()), 128'(0));
    check("t4 no done", 128'(done_cnt - t0), 128'(0));
    check("t4 busy", 128'(busy), 128'(0));
    seq_idle = 1'b1;

    // 5: inter-byte timeout after 7 payload bytes
    words = {rand_word()};
    make_frame(int'($urandom_range(0, 65535)), 0);
    got_q = {};
    t0 = to_cnt;
    for (int i = 0; i < 12; i++) tick(1'b1, tx_q[i]);
    in_valid = 1'b0;
    repeat (TO_CYCLES - 1) tick(1'b0, 8'h00);
    check("t5 no timeout at gap-1", 128'(timeout_err), 128'(0));
    check("t5 busy before timeout", 128'(busy), 128'(1));
    tick(1'b0, 8'h00);
    check("t5 timeout_err at gap", 128'(timeout_err), 128'(1));
    check("t5 busy after timeout", 128'(busy), 128'(0));
    tick(1'b0, 8'h00);
    check("t5 timeout pulse count", 128'(to_cnt - t0), 128'(1));
    check("t5 no writes", 128'(got_q.size()), 128'(0));
    words = {rand_word()};
    make_frame(int'($urandom_range(0, 65535)), 0);
    run_frame("t5 recovery");

    // 6: reset after 10 payload bytes
    words = {rand_word(), rand_word()};
    make_frame(int'($urandom_range(0, 65535)), 0);
    got_q = {};
    for (int i = 0; i < 15; i++) tick(1'b1, tx_q[i]);
    reset = 1'b1;
    tick(1'b0, 8'h00);
    check("t6 outputs after reset", 128'({mem_we, busy, done, reject_err, timeout_err}), 128'(0));
    reset = 1'b0;
    tick(1'b0, 8'h00);
    check("t6 no writes", 128'(got_q.size()), 128'(0));
    run_frame("t6 recovery");

    // seq_idle drops during the second word: first word kept, rest discarded
    words = {rand_word(), rand_word()};
    make_frame(int'($urandom_range(0, 65535)), 0);
    got_q = {};
    for (int i = 0; i < 25; i++) tick(1'b1, tx_q[i]);
    seq_idle = 1'b0;
    tick(1'b0, 8'h00);
    check("drop reject_err", 128'(reject_err), 128'(1));
    seq_idle = 1'b1;
    tick(1'b0, 8'h00);
    check("drop write count", 128'(got_q.size()), 128'(1));
    if (got_q.size() > 0) begin
      check("drop wr0 addr", 128'(got_q[0].a), 128'(exp_q[0].a));
      check("drop wr0 data", 128'(got_q[0].d), 128'(exp_q[0].d));
    end
    check("drop busy", 128'(busy), 128'(0));

    // Random frames, including CNT == 0 and corrupted checksums
    for (int f = 0; f < 6; f++) begin
      int n;
      n = (f == 0) ? 0 : int'($urandom_range(0, 3));
      words = {};
      for (int i = 0; i < n; i++) words.push_back(rand_word());
      make_frame(int'($urandom_range(0, 65535)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 255)) : 0);
      run_frame($sformatf("rand%0d n%0d", f, n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
